// File: rtl/data_mem_hs_pkg.sv
// Shared types and helpers for the handshaked data memory: access sizes, FSM states and
// the byte-lane strobe decode used on stores.
package data_mem_hs_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StResp
  } state_t;

  localparam int unsigned MaxRdLatency = 4;

  function automatic logic [3:0] byte_strobe(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [3:0] strb;
    strb = 4'b0000;
    case (size)
      MEM_BYTE: strb = 4'b0001 << addr_lo;
      MEM_HALF: strb = addr_lo[1] ? 4'b1100 : 4'b0011;
      MEM_WORD: strb = 4'b1111;
      default:  strb = 4'b0000;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/data_mem_hs_if.sv
// Request/response channels between a load/store requester and data_mem_hs.
interface data_mem_hs_if #(
  parameter int unsigned XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic            req_wr;
  logic [1:0]      req_size;
  logic            req_unsigned;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_rdata;
  logic            rsp_err;

  modport master (
    output req_valid, req_wr, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_wr, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_load_align.sv
// Selects the addressed byte/half from a stored word and sign- or zero-extends it.
module mem_load_align
  import data_mem_hs_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      addr_lo,
  input  logic [1:0]      size,
  input  logic            unsigned_ld,
  output logic [XLEN-1:0] result
);
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];
    case (size)
      MEM_BYTE: result = {{(XLEN - 8){byte_sel[7] & ~unsigned_ld}}, byte_sel};
      MEM_HALF: result = {{(XLEN - 16){half_sel[15] & ~unsigned_ld}}, half_sel};
      default:  result = word;
    endcase
  end

endmodule

// File: rtl/data_mem_hs.sv
// Handshaked RV32I data memory: one outstanding access, byte-lane stores, configurable
// read latency and an error response for misaligned, out-of-range or illegal-size accesses.
module data_mem_hs
  import data_mem_hs_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned RD_LATENCY  = 1
) (
  input logic          clk,
  input logic          rst_n,
  data_mem_hs_if.slave bus
);
  localparam int unsigned AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [1:0]  CntInit = (RD_LATENCY > 1) ? 2'(RD_LATENCY - 2) : 2'd0;

  if (XLEN != 32) begin : g_bad_xlen
    $error("data_mem_hs: XLEN must be 32");
  end
  if (RD_LATENCY < 1 || RD_LATENCY > MaxRdLatency) begin : g_bad_lat
    $error("data_mem_hs: RD_LATENCY must be 1..4");
  end

  state_t          state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;
  logic            wr_q, err_q, uns_q;
  logic [1:0]      lo_q, size_q;
  logic [XLEN-1:0] word_q;
  logic [31:0]     mem_q [DEPTH_WORDS];

  logic            accept, req_err, mem_we;
  logic [3:0]      strb;
  logic [AW-1:0]   idx;
  logic [XLEN-1:0] wdata_rep, load_data;

  assign accept = bus.req_valid && (state_q == StIdle);
  assign idx    = bus.req_addr[AW+1:2];
  assign mem_we = accept && bus.req_wr && !req_err;
  assign strb   = byte_strobe(bus.req_size, bus.req_addr[1:0]);

  always_comb begin
    req_err = 1'b0;
    case (bus.req_size)
      MEM_BYTE: req_err = 1'b0;
      MEM_HALF: req_err = bus.req_addr[0];
      MEM_WORD: req_err = |bus.req_addr[1:0];
      default:  req_err = 1'b1;
    endcase
    if ({2'b00, bus.req_addr[XLEN-1:2]} >= DEPTH_WORDS) req_err = 1'b1;
  end

  // Replicating into every lane lets the strobe alone pick the destination bytes.
  always_comb begin
    wdata_rep = bus.req_wdata;
    if (bus.req_size == MEM_BYTE)      wdata_rep = {4{bus.req_wdata[7:0]}};
    else if (bus.req_size == MEM_HALF) wdata_rep = {2{bus.req_wdata[15:0]}};
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) mem_q[idx][8*b +: 8] <= wdata_rep[8*b +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (bus.req_wr || req_err || RD_LATENCY == 1) begin
            state_d = StResp;
          end else begin
            state_d = StBusy;
            cnt_d   = CntInit;
          end
        end
      end
      StBusy: begin
        if (cnt_q == 2'd0) state_d = StResp;
        else               cnt_d   = cnt_q - 2'd1;
      end
      StResp: begin
        if (bus.rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 2'd0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      uns_q   <= 1'b0;
      lo_q    <= 2'd0;
      size_q  <= 2'd0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        wr_q   <= bus.req_wr;
        err_q  <= req_err;
        uns_q  <= bus.req_unsigned;
        lo_q   <= bus.req_addr[1:0];
        size_q <= bus.req_size;
        if (!bus.req_wr && !req_err) word_q <= mem_q[idx];
      end
    end
  end

  mem_load_align #(
    .XLEN(XLEN)
  ) u_align (
    .word       (word_q),
    .addr_lo    (lo_q),
    .size       (size_q),
    .unsigned_ld(uns_q),
    .result     (load_data)
  );

  assign bus.req_ready = (state_q == StIdle);
  assign bus.rsp_valid = (state_q == StResp);
  assign bus.rsp_err   = (state_q == StResp) && err_q;
  assign bus.rsp_rdata = (state_q == StResp && !err_q && !wr_q) ? load_data : '0;

endmodule

// File: tb/tb_data_mem_hs.sv
// Scoreboard bench for data_mem_hs: three builds (RD_LATENCY 2, 1, 4) share one stimulus
// bus; sel picks which build sees req_valid/rsp_ready and which outputs are observed.
module tb_data_mem_hs;
  import data_mem_hs_pkg::*;

  localparam int unsigned DEPTH = 64;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } op_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [7:0]  lat;
  } exp_t;

  logic        clk, rst_n;
  logic        req_valid, req_wr, req_unsigned, rsp_ready;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  sel;
  int          cur_lat;
  int          total, bad, cyc;
  exp_t        sb_q[$];

  logic        obs_req_ready, obs_rsp_valid, obs_err;
  logic [31:0] obs_rdata;

  data_mem_hs_if #(.XLEN(32)) bus2 ();
  data_mem_hs_if #(.XLEN(32)) bus1 ();
  data_mem_hs_if #(.XLEN(32)) bus4 ();

  assign bus2.req_valid = req_valid && sel == 2'd0;
  assign bus2.rsp_ready = rsp_ready && sel == 2'd0;
  assign bus2.req_wr = req_wr;
  assign bus2.req_size = req_size;
  assign bus2.req_unsigned = req_unsigned;
  assign bus2.req_addr = req_addr;
  assign bus2.req_wdata = req_wdata;

  assign bus1.req_valid = req_valid && sel == 2'd1;
  assign bus1.rsp_ready = rsp_ready && sel == 2'd1;
  assign bus1.req_wr = req_wr;
  assign bus1.req_size = req_size;
  assign bus1.req_unsigned = req_unsigned;
  assign bus1.req_addr = req_addr;
  assign bus1.req_wdata = req_wdata;

  assign bus4.req_valid = req_valid && sel == 2'd2;
  assign bus4.rsp_ready = rsp_ready && sel == 2'd2;
  assign bus4.req_wr = req_wr;
  assign bus4.req_size = req_size;
  assign bus4.req_unsigned = req_unsigned;
  assign bus4.req_addr = req_addr;
  assign bus4.req_wdata = req_wdata;

  data_mem_hs #(.XLEN(32), .DEPTH_WORDS(DEPTH), .RD_LATENCY(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2)
  );
  data_mem_hs #(.XLEN(32), .DEPTH_WORDS(DEPTH), .RD_LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );
  data_mem_hs #(.XLEN(32), .DEPTH_WORDS(DEPTH), .RD_LATENCY(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4)
  );

  always_comb begin
    obs_req_ready = bus2.req_ready;
    obs_rsp_valid = bus2.rsp_valid;
    obs_rdata     = bus2.rsp_rdata;
    obs_err       = bus2.rsp_err;
    if (sel == 2'd1) begin
      obs_req_ready = bus1.req_ready;
      obs_rsp_valid = bus1.rsp_valid;
      obs_rdata     = bus1.rsp_rdata;
      obs_err       = bus1.rsp_err;
    end else if (sel == 2'd2) begin
      obs_req_ready = bus4.req_ready;
      obs_rsp_valid = bus4.rsp_valid;
      obs_rdata     = bus4.rsp_rdata;
      obs_err       = bus4.rsp_err;
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic op_t mk(input logic wr, input logic [1:0] sz, input logic uns,
                             input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] er, input logic ee);
    op_t o;
    o = '{wr: wr, size: sz, uns: uns, addr: a, wdata: wd, exp_rdata: er, exp_err: ee};
    return o;
  endfunction

  function automatic exp_t expect_of(input op_t o);
    exp_t e;
    e.rdata = o.exp_rdata;
    e.err   = o.exp_err;
    e.lat   = (o.wr || o.exp_err) ? 8'd1 : 8'(cur_lat);
    return e;
  endfunction

  // Issues one request with rsp_ready=1; lat counts edges from accept (inclusive) to rsp_valid.
  task automatic transact(input op_t o, output logic [31:0] rd, output logic er,
                          output logic [7:0] lat);
    int n;
    @(negedge clk);
    req_wr = o.wr; req_size = o.size; req_unsigned = o.uns;
    req_addr = o.addr; req_wdata = o.wdata; req_valid = 1'b1; rsp_ready = 1'b1;
    n = 0;
    while (!obs_req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 8'd1;
    while (!obs_rsp_valid && lat < 8'd20) begin
      @(posedge clk);
      #1 lat++;
    end
    if (!obs_rsp_valid) lat = 8'hFF;
    rd = obs_rdata;
    er = obs_err;
  endtask

  task automatic test_reset();
    op_t ops[$];
    exp_t ex;
    logic [31:0] rd;
    logic er;
    logic [7:0] lt;
    sel = 2'd0; cur_lat = 2;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    total += 3;
    if (obs_rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got %b want 0", obs_rsp_valid); end
    if (obs_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got %h want 0", obs_rdata); end
    if (obs_err !== 1'b0) begin bad++; $display("FAIL rst_err got %b want 0", obs_err); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 total++;
    if (obs_req_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got %b want 1", obs_req_ready); end
    // Reset while a load response is being held
    @(negedge clk);
    req_wr = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h10;
    req_valid = 1'b1; rsp_ready = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 total++;
    if (obs_rsp_valid !== 1'b1) begin bad++; $display("FAIL midrst_pre got %b want 1", obs_rsp_valid); end
    #2 rst_n = 1'b0;
    #1 total++;
    if (obs_rsp_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got %b want 0", obs_rsp_valid); end
    @(negedge clk);
    rst_n = 1'b1; rsp_ready = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1 total++;
      if (obs_rsp_valid !== 1'b0) begin bad++; $display("FAIL midrst_stale got %b want 0", obs_rsp_valid); end
    end
    total++;
    if (obs_req_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready got %b want 1", obs_req_ready); end
    ops.push_back(mk(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0));
    ops.push_back(mk(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0));
    foreach (ops[i]) begin
      sb_q.push_back(expect_of(ops[i]));
      transact(ops[i], rd, er, lt);
      ex = sb_q.pop_front();
      total += 3;
      if (rd !== ex.rdata) begin bad++; $display("FAIL word[%0d] rdata got %h want %h", i, rd, ex.rdata); end
      if (er !== ex.err) begin bad++; $display("FAIL word[%0d] err got %b want %b", i, er, ex.err); end
      if (lt !== ex.lat) begin bad++; $display("FAIL word[%0d] lat got %0d want %0d", i, lt, ex.lat); end
    end
  endtask

  task automatic test_byte();
    op_t ops[$];
    exp_t ex;
    logic [31:0] rd;
    logic er;
    logic [7:0] lt;
    ops.push_back(mk(1'b1, 2'd0, 1'b0, 32'h13, 32'h12345680, 32'h0, 1'b0));
    ops.push_back(mk(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0));
    ops.push_back(mk(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 32'h00000080, 1'b0));
    ops.push_back(mk(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h80ADBEEF, 1'b0));
    ops.push_back(mk(1'b0, 2'd0, 1'b1, 32'h10, 32'h0, 32'h000000EF, 1'b0));
    ops.push_back(mk(1'b0, 2'd0, 1'b0, 32'h11, 32'h0, 32'hFFFFFFBE, 1'b0));
    ops.push_back(mk(1'b0, 2'd0, 1'b0, 32'h12, 32'h0, 32'hFFFFFFAD, 1'b0));
    foreach (ops[i]) begin
      sb_q.push_back(expect_of(ops[i]));
      transact(ops[i], rd, er, lt);
      ex = sb_q.pop_front();
      total += 3;
      if (rd !== ex.rdata) begin bad++; $display("FAIL byte[%0d] rdata got %h want %h", i, rd, ex.rdata); end
      if (er !== ex.err) begin bad++; $display("FAIL byte[%0d] err got %b want %b", i, er, ex.err); end
      if (lt !== ex.lat) begin bad++; $display("FAIL byte[%0d] lat got %0d want %0d", i, lt, ex.lat); end
    end
  endtask

  task automatic test_half();
    op_t ops[$];
    exp_t ex;
    logic [31:0] rd;
    logic er;
    logic [7:0] lt;
    ops.push_back(mk(1'b1, 2'd1, 1'b0, 32'h12, 32'hABCD1234, 32'h0, 1'b0));
    ops.push_back(mk(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h1234BEEF, 1'b0));
    ops.push_back(mk(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 32'h00001234, 1'b0));
    ops.push_back(mk(1'b0, 2'd1, 1'b0, 32'h10, 32'h0, 32'hFFFFBEEF, 1'b0));
    ops.push_back(mk(1'b0, 2'd1, 1'b1, 32'h10, 32'h0, 32'h0000BEEF, 1'b0));
    ops.push_back(mk(1'b0, 2'd1, 1'b0, 32'h11, 32'h0, 32'h0, 1'b1));
    ops.push_back(mk(1'b1, 2'd2, 1'b0, 32'h12, 32'hFFFFFFFF, 32'h0, 1'b1));
    ops.push_back(mk(1'b1, 2'd1, 1'b0, 32'h13, 32'hFFFFFFFF, 32'h0, 1'b1));
    ops.push_back(mk(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h1234BEEF, 1'b0));
    foreach (ops[i]) begin
      sb_q.push_back(expect_of(ops[i]));
      transact(ops[i], rd, er, lt);
      ex = sb_q.pop_front();
      total += 3;
      if (rd !== ex.rdata) begin bad++; $display("FAIL half[%0d] rdata got %h want %h", i, rd, ex.rdata); end
      if (er !== ex.err) begin bad++; $display("FAIL half[%0d] err got %b want %b", i, er, ex.err); end
      if (lt !== ex.lat) begin bad++; $display("FAIL half[%0d] lat got %0d want %0d", i, lt, ex.lat); end
    end
  endtask

  task automatic test_range();
    op_t ops[$];
    exp_t ex;
    logic [31:0] rd;
    logic er;
    logic [7:0] lt;
    logic [31:0] top_addr;
    top_addr = 4 * DEPTH;
    ops.push_back(mk(1'b1, 2'd2, 1'b0, 32'h0, 32'h11111111, 32'h0, 1'b0));
    ops.push_back(mk(1'b1, 2'd2, 1'b0, top_addr - 4, 32'h5A5A5A5A, 32'h0, 1'b0));
    ops.push_back(mk(1'b0, 2'd2, 1'b0, top_addr, 32'h0, 32'h0, 1'b1));
    ops.push_back(mk(1'b1, 2'd2, 1'b0, top_addr, 32'hFFFFFFFF, 32'h0, 1'b1));
    ops.push_back(mk(1'b0, 2'd0, 1'b0, top_addr + 3, 32'h0, 32'h0, 1'b1));
    ops.push_back(mk(1'b0, 2'd2, 1'b0, 32'h80000000, 32'h0, 32'h0, 1'b1));
    ops.push_back(mk(1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1));
    ops.push_back(mk(1'b1, 2'd3, 1'b0, 32'h0, 32'hFFFFFFFF, 32'h0, 1'b1));
    ops.push_back(mk(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 32'h11111111, 1'b0));
    ops.push_back(mk(1'b0, 2'd2, 1'b0, top_addr - 4, 32'h0, 32'h5A5A5A5A, 1'b0));
    ops.push_back(mk(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h1234BEEF, 1'b0));
    foreach (ops[i]) begin
      sb_q.push_back(expect_of(ops[i]));
      transact(ops[i], rd, er, lt);
      ex = sb_q.pop_front();
      total += 3;
      if (rd !== ex.rdata) begin bad++; $display("FAIL range[%0d] rdata got %h want %h", i, rd, ex.rdata); end
      if (er !== ex.err) begin bad++; $display("FAIL range[%0d] err got %b want %b", i, er, ex.err); end
      if (lt !== ex.lat) begin bad++; $display("FAIL range[%0d] lat got %0d want %0d", i, lt, ex.lat); end
    end
  endtask

  task automatic test_backpressure();
    exp_t ex;
    logic [31:0] rd;
    logic er;
    logic [7:0] lt;
    int n;
    sel = 2'd0; cur_lat = 2;
    @(negedge clk);
    n = 0;
    while (!obs_req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    req_wr = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h10;
    req_valid = 1'b1; rsp_ready = 1'b0;
    sb_q.push_back(expect_of(mk(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h1234BEEF, 1'b0)));
    @(posedge clk);
    // Competing store presented while the load is outstanding
    #1 req_wr = 1'b1; req_wdata = 32'hCAFEBABE;
    n = 0;
    while (!obs_rsp_valid && n < 20) begin
      @(posedge clk);
      #1 n++;
    end
    ex = sb_q.pop_front();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total += 3;
      if (obs_rsp_valid !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d] got %b want 1", k, obs_rsp_valid); end
      if (obs_rdata !== ex.rdata) begin bad++; $display("FAIL bp_rdata[%0d] got %h want %h", k, obs_rdata, ex.rdata); end
      if (obs_req_ready !== 1'b0) begin bad++; $display("FAIL bp_ready[%0d] got %b want 0", k, obs_req_ready); end
    end
    @(negedge clk);
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk);
    #1 total++;
    if (obs_rsp_valid !== 1'b0) begin bad++; $display("FAIL bp_release got %b want 0", obs_rsp_valid); end
    sb_q.push_back(expect_of(mk(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h1234BEEF, 1'b0)));
    transact(mk(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h1234BEEF, 1'b0), rd, er, lt);
    ex = sb_q.pop_front();
    total += 2;
    if (rd !== ex.rdata) begin bad++; $display("FAIL bp_after rdata got %h want %h", rd, ex.rdata); end
    if (er !== ex.err) begin bad++; $display("FAIL bp_after err got %b want %b", er, ex.err); end
  endtask

  task automatic test_back_to_back(input logic [1:0] s, input int lat);
    op_t wr_ops[$];
    op_t ld_ops[$];
    exp_t ex;
    logic [31:0] rd;
    logic er;
    logic [7:0] lt;
    int issued, nresp, prev, budget;
    logic will_acc;
    sel = s; cur_lat = lat;
    wr_ops.push_back(mk(1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344, 32'h0, 1'b0));
    wr_ops.push_back(mk(1'b1, 2'd2, 1'b0, 32'h24, 32'h8899AABB, 32'h0, 1'b0));
    wr_ops.push_back(mk(1'b1, 2'd2, 1'b0, 32'h28, 32'hCAFEF00D, 32'h0, 1'b0));
    wr_ops.push_back(mk(1'b1, 2'd2, 1'b0, 32'h2C, 32'h7F80FF01, 32'h0, 1'b0));
    foreach (wr_ops[i]) begin
      transact(wr_ops[i], rd, er, lt);
      total++;
      if (er !== 1'b0) begin bad++; $display("FAIL b2b_st L%0d[%0d] err got %b want 0", lat, i, er); end
    end
    ld_ops.push_back(mk(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 32'h11223344, 1'b0));
    ld_ops.push_back(mk(1'b0, 2'd2, 1'b0, 32'h24, 32'h0, 32'h8899AABB, 1'b0));
    ld_ops.push_back(mk(1'b0, 2'd0, 1'b0, 32'h2B, 32'h0, 32'hFFFFFFCA, 1'b0));
    ld_ops.push_back(mk(1'b0, 2'd1, 1'b1, 32'h2E, 32'h0, 32'h00007F80, 1'b0));
    ld_ops.push_back(mk(1'b0, 2'd1, 1'b0, 32'h26, 32'h0, 32'hFFFF8899, 1'b0));
    @(negedge clk);
    while (!obs_req_ready) @(negedge clk);
    rsp_ready = 1'b1;
    req_wr = 1'b0; req_size = ld_ops[0].size; req_unsigned = ld_ops[0].uns;
    req_addr = ld_ops[0].addr; req_valid = 1'b1;
    sb_q.push_back(expect_of(ld_ops[0]));
    issued = 0; nresp = 0; prev = -1; budget = 0;
    while (nresp < ld_ops.size() && budget < 200) begin
      will_acc = req_valid && obs_req_ready;
      if (obs_rsp_valid) begin
        ex = sb_q.pop_front();
        total += 2;
        if (obs_rdata !== ex.rdata) begin
          bad++; $display("FAIL b2b L%0d[%0d] rdata got %h want %h", lat, nresp, obs_rdata, ex.rdata);
        end
        if (prev >= 0 && cyc - prev != lat + 1) begin
          bad++; $display("FAIL b2b L%0d[%0d] gap got %0d want %0d", lat, nresp, cyc - prev, lat + 1);
        end
        prev = cyc;
        nresp++;
      end
      @(posedge clk);
      #1;
      if (will_acc) begin
        issued++;
        if (issued < ld_ops.size()) begin
          req_size = ld_ops[issued].size; req_unsigned = ld_ops[issued].uns;
          req_addr = ld_ops[issued].addr;
          sb_q.push_back(expect_of(ld_ops[issued]));
        end else begin
          req_valid = 1'b0;
        end
      end
      @(negedge clk);
      budget++;
    end
    req_valid = 1'b0;
    total++;
    if (nresp != ld_ops.size()) begin
      bad++; $display("FAIL b2b L%0d count got %0d want %0d", lat, nresp, ld_ops.size());
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0; bad = 0; cyc = 0;
    req_valid = 1'b0; req_wr = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b1; sel = 2'd0; cur_lat = 2;
    test_reset();
    test_byte();
    test_half();
    test_range();
    test_backpressure();
    test_back_to_back(2'd0, 2);
    test_back_to_back(2'd1, 1);
    test_back_to_back(2'd2, 4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
